// File: rtl/mcu_spi_receiver.sv
// mcu_spi_receiver: SPI mode-0 slave front-end for the MCU link, clocked on clk.
// Synchronises SCK/MOSI/CS_n and deserialises 24-bit {cmd, addr, data} frames, MSB first.
// A frame whose cmd equals SOFTSW_CMD updates softsw_command and pulses softsw_stb.
// Any other frame pulses cmd_valid. The MCU reads back {FW_VERSION, tx_data} on MISO.
// Ports:
//   clk, rst_n             system clock, async active-low reset
//   mcu_sck/mosi/cs_n      asynchronous SPI inputs from the MCU
//   mcu_miso               SPI data to the MCU (idles high)
//   tx_data[15:0]          status word returned in bytes 2-3 of each frame
//   cmd_valid              one-clk pulse for a completed non-soft-switch frame
//   cmd/addr/data[7:0]     fields of the last completed frame
//   softsw_command[15:0]   {addr, data} of the last soft-switch frame
//   softsw_stb             one-clk pulse when softsw_command is written
// Requires f_clk >= 8 x f_sck. SYNC_STAGES must be at least 2.
module mcu_spi_receiver #(
   parameter logic [7:0]  SOFTSW_CMD  = 8'h0E,
   parameter logic [7:0]  FW_VERSION  = 8'h01,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mcu_sck,
   input  logic        mcu_mosi,
   input  logic        mcu_cs_n,
   output logic        mcu_miso,
   input  logic [15:0] tx_data,
   output logic        cmd_valid,
   output logic [7:0]  cmd,
   output logic [7:0]  addr,
   output logic [7:0]  data,
   output logic [15:0] softsw_command,
   output logic        softsw_stb
);

   localparam int unsigned FRAME_BITS = 24;
   localparam int unsigned CNT_W      = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECV   = 2'd1,
      COMMIT = 2'd2
   } state_e;

   // Input synchronisers and edge-detect copies
   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] cs_n_sync_q, cs_n_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sck_dly_q, sck_dly_d;
   logic                   cs_n_dly_q, cs_n_dly_d;

   // Select-edge qualification after reset
   logic [SYNC_STAGES:0]   settle_q, settle_d;
   logic                   arm_q, arm_d;

   // Frame state
   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [23:0]            rx_shift_q, rx_shift_d;
   logic [23:0]            tx_shift_q, tx_shift_d;

   // Registered outputs
   logic                   mcu_miso_q, mcu_miso_d;
   logic                   cmd_valid_q, cmd_valid_d;
   logic [7:0]             cmd_q, cmd_d;
   logic [7:0]             addr_q, addr_d;
   logic [7:0]             data_q, data_d;
   logic [15:0]            softsw_command_q, softsw_command_d;
   logic                   softsw_stb_q, softsw_stb_d;

   logic                   sck_s, cs_n_s, mosi_s;
   logic                   sck_rise, sck_fall, cs_fall;

   // Synchronised levels and edges
   always_comb begin
      sck_s    = sck_sync_q[SYNC_STAGES-1];
      cs_n_s   = cs_n_sync_q[SYNC_STAGES-1];
      mosi_s   = mosi_sync_q[SYNC_STAGES-1];
      sck_rise = sck_s & ~sck_dly_q;
      sck_fall = ~sck_s & sck_dly_q;
      // cs_n synchronisers reset high; if the pin is already low at release,
      // that reset-induced 1->0 step must not be mistaken for a new select.
      cs_fall  = arm_q & cs_n_dly_q & ~cs_n_s;
   end

   // Next-state and output logic
   always_comb begin
      sck_sync_d       = {sck_sync_q[SYNC_STAGES-2:0], mcu_sck};
      cs_n_sync_d      = {cs_n_sync_q[SYNC_STAGES-2:0], mcu_cs_n};
      mosi_sync_d      = {mosi_sync_q[SYNC_STAGES-2:0], mcu_mosi};
      sck_dly_d        = sck_s;
      cs_n_dly_d       = cs_n_s;
      settle_d         = {settle_q[SYNC_STAGES-1:0], 1'b1};
      // Arm once the chain carries true pin values and cs_n has been seen high
      arm_d            = arm_q | (settle_q[SYNC_STAGES] & cs_n_s);

      state_d          = state_q;
      bit_cnt_d        = bit_cnt_q;
      rx_shift_d       = rx_shift_q;
      tx_shift_d       = tx_shift_q;
      cmd_d            = cmd_q;
      addr_d           = addr_q;
      data_d           = data_q;
      softsw_command_d = softsw_command_q;
      cmd_valid_d      = 1'b0;
      softsw_stb_d     = 1'b0;

      case (state_q)
         IDLE: begin
            bit_cnt_d = '0;
            if (cs_fall) begin
               tx_shift_d = {FW_VERSION, tx_data};
               state_d    = RECV;
            end
         end
         RECV: begin
            if (cs_n_s) begin
               // Deselect before a full frame: drop the partial frame
               bit_cnt_d = '0;
               state_d   = IDLE;
            end else if (sck_rise) begin
               rx_shift_d = {rx_shift_q[22:0], mosi_s};
               bit_cnt_d  = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                  state_d = COMMIT;
               end
            end else if (sck_fall && (bit_cnt_q != '0)) begin
               // Only shift after a rising edge of this frame, so the trailing
               // fall of the previous back-to-back frame does not eat the
               // first bit of the freshly reloaded status word.
               tx_shift_d = {tx_shift_q[22:0], 1'b1};
            end
         end
         COMMIT: begin
            cmd_d  = rx_shift_q[23:16];
            addr_d = rx_shift_q[15:8];
            data_d = rx_shift_q[7:0];
            if (rx_shift_q[23:16] == SOFTSW_CMD) begin
               softsw_command_d = rx_shift_q[15:0];
               softsw_stb_d     = 1'b1;
            end else begin
               cmd_valid_d = 1'b1;
            end
            bit_cnt_d  = '0;
            tx_shift_d = {FW_VERSION, tx_data};
            state_d    = cs_n_s ? IDLE : RECV;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      mcu_miso_d = (state_d == IDLE) ? 1'b1 : tx_shift_d[23];
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync_q       <= '0;
         cs_n_sync_q      <= '1;
         mosi_sync_q      <= '0;
         sck_dly_q        <= 1'b0;
         cs_n_dly_q       <= 1'b1;
         settle_q         <= '0;
         arm_q            <= 1'b0;
         state_q          <= IDLE;
         bit_cnt_q        <= '0;
         rx_shift_q       <= '0;
         tx_shift_q       <= '1;
         mcu_miso_q       <= 1'b1;
         cmd_valid_q      <= 1'b0;
         cmd_q            <= 8'h00;
         addr_q           <= 8'h00;
         data_q           <= 8'h00;
         softsw_command_q <= 16'hFFFF;
         softsw_stb_q     <= 1'b0;
      end else begin
         sck_sync_q       <= sck_sync_d;
         cs_n_sync_q      <= cs_n_sync_d;
         mosi_sync_q      <= mosi_sync_d;
         sck_dly_q        <= sck_dly_d;
         cs_n_dly_q       <= cs_n_dly_d;
         settle_q         <= settle_d;
         arm_q            <= arm_d;
         state_q          <= state_d;
         bit_cnt_q        <= bit_cnt_d;
         rx_shift_q       <= rx_shift_d;
         tx_shift_q       <= tx_shift_d;
         mcu_miso_q       <= mcu_miso_d;
         cmd_valid_q      <= cmd_valid_d;
         cmd_q            <= cmd_d;
         addr_q           <= addr_d;
         data_q           <= data_d;
         softsw_command_q <= softsw_command_d;
         softsw_stb_q     <= softsw_stb_d;
      end
   end

   assign mcu_miso       = mcu_miso_q;
   assign cmd_valid      = cmd_valid_q;
   assign cmd            = cmd_q;
   assign addr           = addr_q;
   assign data           = data_q;
   assign softsw_command = softsw_command_q;
   assign softsw_stb     = softsw_stb_q;

endmodule

// File: tb/tb_mcu_spi_receiver.sv
// tb_mcu_spi_receiver: directed bench for mcu_spi_receiver.
// A behavioural MCU drives mode-0 SPI at f_sck = f_clk/8 and captures MISO on SCK rising.
module tb_mcu_spi_receiver;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        mcu_sck = 1'b0;
   logic        mcu_mosi = 1'b0;
   logic        mcu_cs_n = 1'b1;
   logic        mcu_miso;
   logic [15:0] tx_data = 16'h0000;
   logic        cmd_valid;
   logic [7:0]  cmd;
   logic [7:0]  addr;
   logic [7:0]  data;
   logic [15:0] softsw_command;
   logic        softsw_stb;

   int n_tests = 0;
   int n_fail  = 0;
   int stb_seen = 0;
   int cv_seen  = 0;

   mcu_spi_receiver dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mcu_sck        (mcu_sck),
      .mcu_mosi       (mcu_mosi),
      .mcu_cs_n       (mcu_cs_n),
      .mcu_miso       (mcu_miso),
      .tx_data        (tx_data),
      .cmd_valid      (cmd_valid),
      .cmd            (cmd),
      .addr           (addr),
      .data           (data),
      .softsw_command (softsw_command),
      .softsw_stb     (softsw_stb)
   );

   always #5 clk = ~clk;

   // Count strobe cycles, sampled away from the active edge
   always @(negedge clk) begin
      if (softsw_stb === 1'b1) stb_seen <= stb_seen + 1;
      if (cmd_valid === 1'b1)  cv_seen  <= cv_seen + 1;
   end

   // MCU side: shift bits [first, first+n) of w MSB first, capture MISO on rising
   task automatic send_bits(input logic [23:0] w, input int first, input int n,
                            output logic [23:0] rx);
      rx = '0;
      for (int i = first; i < first + n; i++) begin
         mcu_mosi = w[23-i];
         repeat (4) @(negedge clk);
         rx[23-i] = mcu_miso;
         mcu_sck  = 1'b1;
         repeat (4) @(negedge clk);
         mcu_sck  = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [23:0] w, output logic [23:0] rx);
      mcu_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      send_bits(w, 0, 24, rx);
      repeat (8) @(negedge clk);
      mcu_cs_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (softsw_command !== 16'hFFFF) begin n_fail++; $display("FAIL reset_softsw: got %h want FFFF", softsw_command); end
      n_tests++;
      if (mcu_miso !== 1'b1) begin n_fail++; $display("FAIL reset_miso: got %b want 1", mcu_miso); end
      n_tests++;
      if ({softsw_stb, cmd_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {softsw_stb, cmd_valid}); end
      n_tests++;
      if ({cmd, addr, data} !== 24'h000000) begin n_fail++; $display("FAIL reset_fields: got %h want 000000", {cmd, addr, data}); end
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      n_tests++;
      if (softsw_command !== 16'hFFFF) begin n_fail++; $display("FAIL release_softsw: got %h want FFFF", softsw_command); end
      n_tests++;
      if (mcu_miso !== 1'b1) begin n_fail++; $display("FAIL release_miso: got %b want 1", mcu_miso); end
      n_tests++;
      if (stb_seen + cv_seen !== 0) begin n_fail++; $display("FAIL release_strobes: got %0d pulses want 0", stb_seen + cv_seen); end
   endtask

   task automatic test_softsw();
      logic [23:0] rx;
      logic [23:0] w = 24'h0E0602;
      int s0 = stb_seen;
      int c0 = cv_seen;
      tx_data  = 16'h0000;
      mcu_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      send_bits(w, 0, 23, rx);
      // Last bit by hand to check pin-to-strobe latency of SYNC_STAGES+2 clk
      mcu_mosi = w[0];
      repeat (4) @(negedge clk);
      rx[0]   = mcu_miso;
      mcu_sck = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if (softsw_stb !== 1'b0) begin n_fail++; $display("FAIL softsw_latency_early: got %b want 0", softsw_stb); end
      @(negedge clk);
      n_tests++;
      if (softsw_stb !== 1'b1) begin n_fail++; $display("FAIL softsw_latency: got %b want 1", softsw_stb); end
      mcu_sck = 1'b0;
      repeat (8) @(negedge clk);
      mcu_cs_n = 1'b1;
      repeat (8) @(negedge clk);
      n_tests++;
      if (softsw_command !== 16'h0602) begin n_fail++; $display("FAIL softsw_value: got %h want 0602", softsw_command); end
      n_tests++;
      if (stb_seen - s0 !== 1) begin n_fail++; $display("FAIL softsw_stb_count: got %0d want 1", stb_seen - s0); end
      n_tests++;
      if (cv_seen - c0 !== 0) begin n_fail++; $display("FAIL softsw_no_cmd_valid: got %0d want 0", cv_seen - c0); end
      n_tests++;
      if (rx !== 24'h010000) begin n_fail++; $display("FAIL softsw_miso: got %h want 010000", rx); end
   endtask

   task automatic test_generic();
      logic [23:0] rx;
      int s0 = stb_seen;
      int c0 = cv_seen;
      send_frame(24'h011234, rx);
      n_tests++;
      if (cv_seen - c0 !== 1) begin n_fail++; $display("FAIL generic_cmd_valid_count: got %0d want 1", cv_seen - c0); end
      n_tests++;
      if (stb_seen - s0 !== 0) begin n_fail++; $display("FAIL generic_no_stb: got %0d want 0", stb_seen - s0); end
      n_tests++;
      if ({cmd, addr, data} !== 24'h011234) begin n_fail++; $display("FAIL generic_fields: got %h want 011234", {cmd, addr, data}); end
      n_tests++;
      if (softsw_command !== 16'h0602) begin n_fail++; $display("FAIL generic_softsw_hold: got %h want 0602", softsw_command); end
   endtask

   task automatic test_miso();
      logic [23:0] rx;
      tx_data = 16'hA55A;
      send_frame(24'h000000, rx);
      n_tests++;
      if (rx !== 24'h01A55A) begin n_fail++; $display("FAIL miso_readback: got %h want 01A55A", rx); end
      n_tests++;
      if (mcu_miso !== 1'b1) begin n_fail++; $display("FAIL miso_idle: got %b want 1", mcu_miso); end
   endtask

   task automatic test_abort();
      logic [23:0] rx;
      int s0 = stb_seen;
      int c0 = cv_seen;
      tx_data  = 16'h0000;
      mcu_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      send_bits(24'h0EFFFF, 0, 13, rx);
      repeat (8) @(negedge clk);
      mcu_cs_n = 1'b1;
      repeat (8) @(negedge clk);
      n_tests++;
      if ((stb_seen - s0) + (cv_seen - c0) !== 0) begin n_fail++; $display("FAIL abort_no_strobe: got %0d want 0", (stb_seen - s0) + (cv_seen - c0)); end
      n_tests++;
      if (softsw_command !== 16'h0602) begin n_fail++; $display("FAIL abort_softsw_hold: got %h want 0602", softsw_command); end
      send_frame(24'h0E0B01, rx);
      n_tests++;
      if (softsw_command !== 16'h0B01) begin n_fail++; $display("FAIL abort_next_frame: got %h want 0B01", softsw_command); end
      n_tests++;
      if (stb_seen - s0 !== 1) begin n_fail++; $display("FAIL abort_next_stb: got %0d want 1", stb_seen - s0); end
   endtask

   task automatic test_back_to_back();
      logic [23:0] rx1, rx2;
      int s0 = stb_seen;
      tx_data  = 16'h1234;
      mcu_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      send_bits(24'h0E0002, 0, 24, rx1);
      repeat (8) @(negedge clk);
      n_tests++;
      if (softsw_command !== 16'h0002) begin n_fail++; $display("FAIL b2b_first_value: got %h want 0002", softsw_command); end
      send_bits(24'h0E0701, 0, 24, rx2);
      repeat (8) @(negedge clk);
      mcu_cs_n = 1'b1;
      repeat (8) @(negedge clk);
      n_tests++;
      if (stb_seen - s0 !== 2) begin n_fail++; $display("FAIL b2b_stb_count: got %0d want 2", stb_seen - s0); end
      n_tests++;
      if (softsw_command !== 16'h0701) begin n_fail++; $display("FAIL b2b_final_value: got %h want 0701", softsw_command); end
      n_tests++;
      if (rx1 !== 24'h011234) begin n_fail++; $display("FAIL b2b_miso_frame1: got %h want 011234", rx1); end
      n_tests++;
      if (rx2 !== 24'h011234) begin n_fail++; $display("FAIL b2b_miso_frame2: got %h want 011234", rx2); end
   endtask

   task automatic test_reset_midframe();
      logic [23:0] rx;
      int s0 = stb_seen;
      int c0 = cv_seen;
      mcu_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      send_bits(24'h0E1234, 0, 10, rx);
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (softsw_command !== 16'hFFFF) begin n_fail++; $display("FAIL midrst_softsw: got %h want FFFF", softsw_command); end
      n_tests++;
      if (mcu_miso !== 1'b1) begin n_fail++; $display("FAIL midrst_miso: got %b want 1", mcu_miso); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      // MCU is unaware of the reset and finishes its frame
      send_bits(24'h0E1234, 10, 14, rx);
      repeat (8) @(negedge clk);
      mcu_cs_n = 1'b1;
      repeat (8) @(negedge clk);
      n_tests++;
      if ((stb_seen - s0) + (cv_seen - c0) !== 0) begin n_fail++; $display("FAIL midrst_no_strobe: got %0d want 0", (stb_seen - s0) + (cv_seen - c0)); end
      n_tests++;
      if (softsw_command !== 16'hFFFF) begin n_fail++; $display("FAIL midrst_hold: got %h want FFFF", softsw_command); end
      send_frame(24'h0E0506, rx);
      n_tests++;
      if (softsw_command !== 16'h0506) begin n_fail++; $display("FAIL midrst_fresh_frame: got %h want 0506", softsw_command); end
      n_tests++;
      if (stb_seen - s0 !== 1) begin n_fail++; $display("FAIL midrst_fresh_stb: got %0d want 1", stb_seen - s0); end
   endtask

   initial begin
      test_reset();
      test_softsw();
      test_generic();
      test_miso();
      test_abort();
      test_back_to_back();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Safety bound on total run time
   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
